// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr
//  Description : Round-robin arbiter that gives NUM_PORTS compute units access
//                to one shared single-beat memory port. It uses a three-state
//                flow (IDLE -> ACCESS -> DONE) with optional port locking for
//                uninterrupted bursts.
//                Optional feature macro: MEM_ARB_TIMEOUT_EN (ACCESS watchdog
//                that completes a stuck beat with an error pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int NUM_PORTS      = 9,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  port_req,
    input  logic [NUM_PORTS-1:0]                  port_we,
    input  logic [NUM_PORTS-1:0]                  port_lock,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       port_wdata,
    output logic [NUM_PORTS-1:0]                  port_ack,
    output logic [NUM_PORTS-1:0]                  port_err,
    output logic [DATA_WIDTH-1:0]                 port_rdata,
    output logic                                  mem_sel,
    output logic                                  mem_w,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    input  logic                                  mem_ready,
    output logic                                  busy,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id
);

    localparam int c_ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    // Elaboration-time sanity check of the configuration.
    if (NUM_PORTS < 1 || NUM_PORTS > 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter_rr: NUM_PORTS must be 1..32 and TIMEOUT_CYCLES >= 1");
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [c_ID_W-1:0]     r_rr_ptr;
    logic                  r_lock;
    logic [c_ID_W-1:0]     r_grant_id;
    logic                  r_mem_sel;
    logic                  r_mem_w;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [NUM_PORTS-1:0]  r_port_ack;
    logic [DATA_WIDTH-1:0] r_port_rdata;

    logic [1:0]            w_state_nxt;
    logic [c_ID_W-1:0]     w_rr_ptr_nxt;
    logic                  w_lock_nxt;
    logic [c_ID_W-1:0]     w_grant_id_nxt;
    logic                  w_mem_sel_nxt;
    logic                  w_mem_w_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] w_mem_wdata_nxt;
    logic [NUM_PORTS-1:0]  w_port_ack_nxt;
    logic [DATA_WIDTH-1:0] w_port_rdata_nxt;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [NUM_PORTS-1:0]  r_port_err;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [NUM_PORTS-1:0]  w_port_err_nxt;
    logic [c_TMO_W-1:0]    w_tmo_cnt_nxt;
`endif

    // ------------------------------------------------------------------------
    // Per-port views of the flattened address / write-data buses
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = port_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[g] = port_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic                 w_lock_hold;
    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_found;
    logic [c_ID_W-1:0]    w_win;
    logic [c_ID_W:0]      w_sum;
    logic [NUM_PORTS-1:0] w_gid_onehot;

    assign w_lock_hold = r_lock & port_req[r_grant_id];

    // A held lock narrows eligibility to the locked port only.
    always_comb begin
        w_gid_onehot             = '0;
        w_gid_onehot[r_grant_id] = 1'b1;
        w_elig                   = w_lock_hold ? w_gid_onehot : port_req;
    end

    // First eligible port scanning upward from rr_ptr+1 (wrapping at NUM_PORTS).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_ID_W+1)'(i);
            if (w_sum >= (c_ID_W+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (c_ID_W+1)'(NUM_PORTS);
            end
            if (!w_found && w_elig[w_sum[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_ID_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    // Every registered value defaults to holding; each state overrides what it owns.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_nxt       = r_lock;
        w_grant_id_nxt   = r_grant_id;
        w_mem_sel_nxt    = r_mem_sel;
        w_mem_w_nxt      = r_mem_w;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_port_ack_nxt   = r_port_ack;
        w_port_rdata_nxt = r_port_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        w_port_err_nxt   = r_port_err;
        w_tmo_cnt_nxt    = r_tmo_cnt;
`endif

        case (r_state)
            c_S_IDLE: begin
                // A lock whose owner has dropped its request is released here.
                if (!w_lock_hold) begin
                    w_lock_nxt = 1'b0;
                end
                if (w_found) begin
                    w_state_nxt     = c_S_ACCESS;
                    w_grant_id_nxt  = w_win;
                    w_mem_sel_nxt   = 1'b1;
                    w_mem_w_nxt     = port_we[w_win];
                    w_mem_addr_nxt  = w_addr_arr[w_win];
                    w_mem_wdata_nxt = w_wdata_arr[w_win];
                    w_lock_nxt      = port_lock[w_win];
                    // A locked re-grant leaves the round-robin pointer alone.
                    if (!w_lock_hold) begin
                        w_rr_ptr_nxt = w_win;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    w_tmo_cnt_nxt = '0;
`endif
                end
            end

            c_S_ACCESS: begin
`ifdef MEM_ARB_TIMEOUT_EN
                w_tmo_cnt_nxt = r_tmo_cnt + c_TMO_W'(1);
`endif
                // mem_ready takes priority over a coincident timeout.
                if (mem_ready) begin
                    w_state_nxt    = c_S_DONE;
                    w_mem_sel_nxt  = 1'b0;
                    w_mem_w_nxt    = 1'b0;
                    w_port_ack_nxt = w_gid_onehot;
                    if (!r_mem_w) begin
                        w_port_rdata_nxt = mem_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt      = c_S_DONE;
                    w_mem_sel_nxt    = 1'b0;
                    w_mem_w_nxt      = 1'b0;
                    w_port_ack_nxt   = w_gid_onehot;
                    w_port_err_nxt   = w_gid_onehot;
                    w_port_rdata_nxt = '0;
                    w_lock_nxt       = 1'b0;
                end
`endif
            end

            c_S_DONE: begin
                w_state_nxt    = c_S_IDLE;
                w_port_ack_nxt = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                w_port_err_nxt = '0;
`endif
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_S_IDLE;
            r_rr_ptr     <= c_ID_W'(NUM_PORTS - 1);
            r_lock       <= 1'b0;
            r_grant_id   <= '0;
            r_mem_sel    <= 1'b0;
            r_mem_w      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_port_ack   <= '0;
            r_port_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_port_err   <= '0;
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock       <= w_lock_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_mem_sel    <= w_mem_sel_nxt;
            r_mem_w      <= w_mem_w_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_port_ack   <= w_port_ack_nxt;
            r_port_rdata <= w_port_rdata_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            r_port_err   <= w_port_err_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign port_ack   = r_port_ack;
    assign port_rdata = r_port_rdata;
    assign mem_sel    = r_mem_sel;
    assign mem_w      = r_mem_w;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state != c_S_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign port_err = r_port_err;
`else
    assign port_err = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr
//  Description : Scoreboard bench for mem_arbiter_rr. Per-port drivers replay
//                beat lists, a memory model answers with fixed latency, and a
//                monitor checks every ack against the expected queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

    localparam int NP = 9;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ID_W = 4;
    localparam int LATENCY = 2;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     port_req, port_we, port_lock;
    logic [NP*AW-1:0]  port_addr;
    logic [NP*DW-1:0]  port_wdata;
    logic [NP-1:0]     port_ack, port_err;
    logic [DW-1:0]     port_rdata;
    logic              mem_sel, mem_w;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic [ID_W-1:0]   grant_id;

    mem_arbiter_rr #(
        .NUM_PORTS      (NP),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .port_req   (port_req),
        .port_we    (port_we),
        .port_lock  (port_lock),
        .port_addr  (port_addr),
        .port_wdata (port_wdata),
        .port_ack   (port_ack),
        .port_err   (port_err),
        .port_rdata (port_rdata),
        .mem_sel    (mem_sel),
        .mem_w      (mem_w),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic          lock;
    } beat_t;

    typedef struct {
        int          port;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    beat_t beats [NP][8];
    int    nb    [NP];
    int    head  [NP];
    exp_t  sb    [$];
    logic  stall;

    task automatic load(input int k, input logic [AW-1:0] a, input logic we,
                        input logic [DW-1:0] wd, input logic lk);
        beats[k][nb[k]] = '{addr: a, we: we, wdata: wd, lock: lk};
        nb[k]++;
    endtask

    task automatic push(input int k, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.port  = k;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // Port drivers: hold each beat until acked, then present the next one
    // ------------------------------------------------------------------------
    initial begin
        port_req   = '0;
        port_we    = '0;
        port_lock  = '0;
        port_addr  = '0;
        port_wdata = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NP; k++) begin
                if (port_ack[k] && head[k] < nb[k]) head[k]++;
                if (head[k] < nb[k]) begin
                    port_req[k]              = 1'b1;
                    port_we[k]               = beats[k][head[k]].we;
                    port_lock[k]             = beats[k][head[k]].lock;
                    port_addr[k*AW +: AW]    = beats[k][head[k]].addr;
                    port_wdata[k*DW +: DW]   = beats[k][head[k]].wdata;
                end else begin
                    port_req[k]  = 1'b0;
                    port_lock[k] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory model: default contents 0xA5A5_0000 | addr, 0x0100 holds 5
    // ------------------------------------------------------------------------
    logic [DW-1:0] mem [0:65535];
    initial begin
        int lat;
        lat       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'hA5A5_0000 | DW'(i);
        mem[16'h0100] = 32'd5;
        forever begin
            @(negedge clk);
            if (mem_sel === 1'b1 && !stall) begin
                lat++;
                if (lat >= LATENCY) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_w) mem[mem_addr] = mem_wdata;
                end else begin
                    mem_ready = 1'b0;
                end
            end else begin
                lat       = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: pop and compare on every ack pulse
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        logic [NP-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && port_ack !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", port_ack, '0);
                end else begin
                    e = sb.pop_front();
                    oh = '0;
                    oh[e.port] = 1'b1;
                    chk("ack_port", port_ack, oh);
                    chk("ack_err", port_err, e.err ? oh : '0);
                    chk("ack_rdata", port_rdata, e.rdata);
                    chk("done_mem_sel", mem_sel, 1'b0);
                    chk("done_busy", busy, 1'b1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bounded waits
    // ------------------------------------------------------------------------
    task automatic wait_sel(input string name);
        int t;
        t = 0;
        while (mem_sel !== 1'b1 && t < 50) begin
            @(posedge clk); #2;
            t++;
        end
        if (mem_sel !== 1'b1) chk(name, mem_sel, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && t < 400) begin
            @(posedge clk); #2;
            t++;
        end
        if (sb.size() != 0 || busy !== 1'b0) chk(name, 64'(sb.size()), 64'd0);
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        int cnt;
        rst   = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_sel", mem_sel, 1'b0);
        chk("rst_mem_w", mem_w, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_ack", port_ack, '0);
        chk("rst_err", port_err, '0);
        chk("rst_rdata", port_rdata, '0);
        chk("rst_grant", grant_id, '0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #2;

        // Single read of 0x0100 with one-cycle grant latency.
        load(0, 16'h0100, 1'b0, '0, 1'b0);
        push(0, 32'd5, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("lat_mem_sel", mem_sel, 1'b1);
        chk("lat_mem_addr", mem_addr, 16'h0100);
        chk("lat_mem_w", mem_w, 1'b0);
        chk("lat_grant", grant_id, 4'd0);
        chk("lat_busy", busy, 1'b1);
        wait_idle("t1_drain");

        // All ports at once after reset: strict order 0..8.
        do_reset();
        @(posedge clk); #2;
        for (int k = 0; k < NP; k++) begin
            load(k, AW'(16'h0010 + k), 1'b0, '0, 1'b0);
            push(k, 32'hA5A5_0010 + DW'(k), 1'b0);
        end
        wait_idle("t2_drain");

        // Ports 2 and 5 continuously requesting: 2,5,2,5.
        load(2, 16'h0020, 1'b0, '0, 1'b0);
        load(2, 16'h0021, 1'b0, '0, 1'b0);
        load(5, 16'h0050, 1'b0, '0, 1'b0);
        load(5, 16'h0051, 1'b0, '0, 1'b0);
        push(2, 32'hA5A5_0020, 1'b0);
        push(5, 32'hA5A5_0050, 1'b0);
        push(2, 32'hA5A5_0021, 1'b0);
        push(5, 32'hA5A5_0051, 1'b0);
        wait_idle("t3_drain");

        // Port 3 locked burst of four writes; port 1 waits until it ends.
        // Write beats leave port_rdata at the last read value (0xA5A50051).
        for (int i = 0; i < 4; i++) begin
            load(3, AW'(16'h0200 + i), 1'b1, 32'h3000_0000 + DW'(i), (i < 3) ? 1'b1 : 1'b0);
            push(3, 32'hA5A5_0051, 1'b0);
        end
        push(1, 32'h3000_0003, 1'b0);
        wait_sel("t4_first_grant");
        load(1, 16'h0203, 1'b0, '0, 1'b0);
        wait_idle("t4_drain");

        // Reset in the middle of port 4's access.
        stall = 1'b1;
        load(4, 16'h0040, 1'b0, '0, 1'b0);
        wait_sel("t5_grant");
        chk("t5_grant_id", grant_id, 4'd4);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_rst_mem_sel", mem_sel, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ack", port_ack, '0);
        chk("t5_rst_grant", grant_id, '0);
        #1;
        load(0, 16'h0005, 1'b0, '0, 1'b0);
        push(0, 32'hA5A5_0005, 1'b0);
        push(4, 32'hA5A5_0040, 1'b0);
        stall = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        wait_idle("t5_drain");

`ifdef MEM_ARB_TIMEOUT_EN
        // Stuck memory: eight ACCESS cycles, then ack+err with zero data.
        stall = 1'b1;
        load(0, 16'h0100, 1'b0, '0, 1'b0);
        push(0, 32'd0, 1'b1);
        wait_sel("t6_grant");
        cnt = 1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #2;
            if (mem_sel === 1'b1) cnt++;
            else break;
        end
        chk("t6_sel_cycles", 64'(cnt), 64'd8);
        wait_idle("t6_drain");
        stall = 1'b0;
`else
        cnt = 0;
`endif

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
